gated_pmt_counter_mc: RTL
=========================

// Module: gated_pmt_counter_mc
// PURPOSE
//  Multi-channel gated photon counter for the PL side of the qubit readout. Counts PMT pulse rising edges
//  per channel while GATE is high. Snapshots all channels on each SAMPLE_TICK rising edge, plus one final
//  snapshot at gate close, into a valid/ready output toward the PS/DMA path. Adds saturate/wrap mode,
//  snapshot backpressure with overrun flagging, and a tagged last-of-gate snapshot.
// PARAMETERS
//  NCH    4  number of PMT channels
//  WIDTH  8  per-channel counter/output width
//  SIZE   8  wrap/saturate limit is 2**SIZE-1; SIZE <= WIDTH
//  SAT    0  1: counters saturate at limit; 0: counters wrap to 0
// PORTS
//  CLK          in   1          system clock, 100 MHz; the only clock
//  RST          in   1          asynchronous, active-high reset
//  GATE         in   1          counting window, async input
//  PMT          in   NCH        pulse inputs, async
//  SAMPLE_TICK  in   1          ~33 kHz sample strobe, async; rising edge is used
//  SNAP_READY   in   1          consumer accepts a snapshot
//  SNAP_VALID   out  1          snapshot held on COUNTER
//  COUNTER      out  NCH*WIDTH  snapshot; channel i at [i*WIDTH +: WIDTH]
//  SNAP_LAST    out  1          snapshot was taken at gate close
//  SNAP_OVR     out  1          1-cycle pulse: a snapshot was dropped because one was still pending
//  INTR         out  1          1-cycle pulse on each SNAP_VALID 0->1
//  CLEAR        out  1          1 while the FSM is IDLE (gate closed)
// BEHAVIOUR
//  Reset: all counters 0, FSM IDLE, SNAP_VALID=0, COUNTER=0, SNAP_LAST=0, SNAP_OVR=0, INTR=0, CLEAR=1.
//  Inputs: GATE, PMT[i] and SAMPLE_TICK each pass a 2-FF synchroniser, then a registered rising/falling
//   edge detect. A pin edge sampled at cycle k is acted on at cycle k+3.
//  FSM:
//   IDLE:  on gate rise -> clear all counters -> ARMED. The clear wins over a same-cycle pulse edge.
//   ARMED: each PMT[i] edge increments cnt[i]. At the limit 2**SIZE-1: SAT=1 holds; SAT=0 wraps to 0.
//          On tick edge -> snapshot request, stay in ARMED.
//          On gate fall -> FLUSH. A tick in the same cycle produces no extra snapshot.
//   FLUSH: one cycle; final snapshot request with SNAP_LAST=1 -> IDLE.
//          Counters hold their values until the next gate rise.
//  Snapshot request:
//   If SNAP_VALID=0 or (SNAP_VALID & SNAP_READY) in that cycle: load COUNTER with the pre-increment cnt
//    values (a pulse edge in the same cycle lands in the next snapshot), and set SNAP_VALID next cycle.
//   Otherwise drop the request and pulse SNAP_OVR. A dropped FLUSH snapshot is flagged the same way.
//  Handshake: COUNTER, SNAP_VALID and SNAP_LAST are stable while SNAP_VALID & ~SNAP_READY.
//   Handshake completes when VALID & READY. VALID deasserts next cycle unless a new snapshot loads.
//  INTR: asserted in the cycle SNAP_VALID goes 0->1. No INTR for back-to-back loads during acceptance.
//  Reset mid-gate: everything returns to reset values. After release, counting requires a fresh gate rise;
//   a gate already high at release is ignored until it falls and rises again.
// CONFIGURATION
//  `PMT_DEGLITCH_EN defined: a PMT edge counts only if the synchronised level stays high for 2 consecutive
//   cycles. Single-cycle glitches are rejected; pin-to-count latency becomes k+4.
//  Not defined: every synchronised rising edge counts; latency k+3.
// STRUCTURE
//  Package gated_pmt_counter_pkg holds:
//   - the FSM state enum IDLE/ARMED/FLUSH
//   - SYNC_STAGES=2
//   - the function lim(SIZE) = 2**SIZE-1
//  Sub-module pmt_edge_sync (synchroniser + rise/fall detect + optional deglitch), instanced NCH+2 times.
//  Counters, FSM and snapshot register stay in this top.
// TESTING
//  1 NCH=4, SAT=0, SNAP_READY=1, 5 pulses on ch0 and 3 on ch2 inside the gate, then a tick
//    -> COUNTER ch0=5, ch1=0, ch2=3, ch3=0; SNAP_VALID and INTR each pulse 1 cycle; SNAP_LAST=0.
//  2 SAT=0, SIZE=8, 257 pulses on ch1, then gate fall -> final snapshot ch1=1, SNAP_LAST=1;
//    rerun with SAT=1 -> ch1=255.
//  3 SNAP_READY=0, two ticks 30 us apart -> first snapshot held unchanged; second tick gives SNAP_OVR=1 for
//    1 cycle; after READY=1, exactly one handshake with the first values.
//  4 Gate rise in the same cycle as a ch0 pulse edge, then 2 more pulses, gate fall -> ch0=2;
//    tick coincident with gate fall -> exactly one snapshot, SNAP_LAST=1.
//  5 RST pulsed mid-gate after 10 pulses, GATE kept high -> all outputs at reset values, no counting until
//    gate fall then rise; then 4 pulses -> 4.
//  6 `PMT_DEGLITCH_EN defined, ch3 driven with 1-cycle and 3-cycle high pulses (4 each) -> ch3=4;
//    without the macro -> ch3=8.

Source files
------------

// File: rtl/gated_pmt_counter_mc_pkg.sv
// Shared types and constants for the gated multi-channel PMT counter.
// The optional PMT_DEGLITCH_EN macro is consumed by gated_pmt_counter_mc.
package gated_pmt_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Counter limit for a SIZE-bit counting range.
  function automatic int unsigned lim(input int unsigned size);
    return (32'd1 << size) - 32'd1;
  endfunction

endpackage

// File: rtl/gated_pmt_counter_mc_if.sv
// Input pins and snapshot valid/ready bus of the gated PMT counter.
interface gated_pmt_counter_mc_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8
);
  logic                 gate;
  logic [NCH-1:0]       pmt;
  logic                 sample_tick;
  logic                 snap_ready;
  logic                 snap_valid;
  logic [NCH*WIDTH-1:0] counter;
  logic                 snap_last;
  logic                 snap_ovr;
  logic                 intr;
  logic                 clear;

  modport master (
    input  gate, pmt, sample_tick, snap_ready,
    output snap_valid, counter, snap_last, snap_ovr, intr, clear
  );

  modport slave (
    output gate, pmt, sample_tick, snap_ready,
    input  snap_valid, counter, snap_last, snap_ovr, intr, clear
  );
endinterface

// File: rtl/gated_pmt_counter_mc_pmt_edge_sync.sv
// Two-stage synchroniser with registered rise/fall detection and an optional
// two-cycle-high qualification of rising edges.
module pmt_edge_sync
  import gated_pmt_counter_pkg::*;
#(
  parameter bit DEGLITCH = 1'b0,
  parameter bit RST_LVL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lvl;
  logic                   lvl_d1;
  logic                   lvl_d2;

  assign lvl = sync[SYNC_STAGES-1];

  // RST_LVL=1 makes a level already high at reset release look old, not new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= {SYNC_STAGES{RST_LVL}};
      lvl_d1 <= RST_LVL;
      lvl_d2 <= RST_LVL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pin};
      lvl_d1 <= lvl;
      lvl_d2 <= lvl_d1;
      rise   <= DEGLITCH ? (lvl & lvl_d1 & ~lvl_d2) : (lvl & ~lvl_d1);
      fall   <= ~lvl & lvl_d1;
    end
  end

endmodule

// File: rtl/gated_pmt_counter_mc.sv
// Gated multi-channel photon counter with valid/ready snapshot output.
// Define PMT_DEGLITCH_EN to count only PMT pulses high for >= 2 cycles.
module gated_pmt_counter_mc
  import gated_pmt_counter_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 8,
  parameter bit          SAT   = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  gated_pmt_counter_mc_if.master bus
);

`ifdef PMT_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif

  localparam logic [WIDTH-1:0] LIM = WIDTH'(lim(SIZE));

  logic [NCH-1:0]       pmt_rise;
  logic [NCH-1:0]       pmt_fall_unused;
  logic                 gate_rise;
  logic                 gate_fall;
  logic                 tick_rise;
  logic                 tick_fall_unused;
  logic [WIDTH-1:0]     cnt [NCH];
  logic [NCH*WIDTH-1:0] cnt_flat;
  state_t               state;
  state_t               state_d;
  logic                 snap_req_c;
  logic                 snap_last_c;
  logic                 cnt_clear_c;
  logic                 cnt_en_c;
  logic                 can_load_c;

  for (genvar i = 0; i < NCH; i++) begin : g_pmt
    pmt_edge_sync #(.DEGLITCH(DEGLITCH), .RST_LVL(1'b0)) u_pmt (
      .clk (clk),
      .rst (rst),
      .pin (bus.pmt[i]),
      .rise(pmt_rise[i]),
      .fall(pmt_fall_unused[i])
    );
  end

  pmt_edge_sync #(.DEGLITCH(1'b0), .RST_LVL(1'b1)) u_gate (
    .clk (clk),
    .rst (rst),
    .pin (bus.gate),
    .rise(gate_rise),
    .fall(gate_fall)
  );

  pmt_edge_sync #(.DEGLITCH(1'b0), .RST_LVL(1'b0)) u_tick (
    .clk (clk),
    .rst (rst),
    .pin (bus.sample_tick),
    .rise(tick_rise),
    .fall(tick_fall_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Gate close takes priority over a coincident tick: only the FLUSH snapshot is taken.
  always_comb begin
    state_d     = state;
    snap_req_c  = 1'b0;
    snap_last_c = 1'b0;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (gate_rise) begin
          cnt_clear_c = 1'b1;
          state_d     = ARMED;
        end
      end
      ARMED: begin
        cnt_en_c = 1'b1;
        if (gate_fall)      state_d    = FLUSH;
        else if (tick_rise) snap_req_c = 1'b1;
      end
      FLUSH: begin
        snap_req_c  = 1'b1;
        snap_last_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cnt_clear_c)
          cnt[i] <= '0;
        else if (cnt_en_c && pmt_rise[i])
          cnt[i] <= (cnt[i] == LIM) ? (SAT ? LIM : '0) : cnt[i] + WIDTH'(1);
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int unsigned i = 0; i < NCH; i++) cnt_flat[i*WIDTH +: WIDTH] = cnt[i];
  end

  assign can_load_c = ~bus.snap_valid | bus.snap_ready;

  // Snapshot register: loads pre-increment counts, drops and flags when still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.snap_valid <= 1'b0;
      bus.counter    <= '0;
      bus.snap_last  <= 1'b0;
      bus.snap_ovr   <= 1'b0;
      bus.intr       <= 1'b0;
      bus.clear      <= 1'b1;
    end else begin
      bus.snap_ovr <= snap_req_c & ~can_load_c;
      bus.intr     <= 1'b0;
      bus.clear    <= (state_d == IDLE);
      if (snap_req_c && can_load_c) begin
        bus.counter    <= cnt_flat;
        bus.snap_valid <= 1'b1;
        bus.snap_last  <= snap_last_c;
        bus.intr       <= ~bus.snap_valid;
      end else if (bus.snap_valid && bus.snap_ready) begin
        bus.snap_valid <= 1'b0;
      end
    end
  end

endmodule
